// File: rtl/jtag_bridge_pkg.sv
// Shared types and constants for the JTAG user-chain register bridge.
// Contents: FSM state enum, status-bit offsets (relative to DATA_W) within
// the capture frame, and JTAGG IR codes for the ER1/ER2 user chains.
package jtag_bridge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  // Status bit offsets above the read-data field of the capture frame
  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_OVR  = 1;
  localparam int unsigned STAT_TMO  = 2;

  // JTAGG user-chain instruction codes
  localparam logic [7:0] ER1 = 8'h32;
  localparam logic [7:0] ER2 = 8'h38;

endpackage

// File: rtl/jtag_dr_shifter.sv
// Generic FW-bit JTAG data register: parallel capture load, LSB-first
// serial shift, serial out from bit 0. Reusable for any user chain.
// Ports:
//   clk, rst_n      clock, async active-low reset (register clears to 0)
//   capture_i       load capture_data_i (has priority over shift_i)
//   shift_i         shift right by one, tdi_i enters at the MSB
//   tdi_i           serial input
//   capture_data_i  parallel load value
//   data_o          current register contents
//   tdo_o           serial output, bit 0 of the register (combinational)
module jtag_dr_shifter #(
  parameter int unsigned FW = 41
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          capture_i,
  input  logic          shift_i,
  input  logic          tdi_i,
  input  logic [FW-1:0] capture_data_i,
  output logic [FW-1:0] data_o,
  output logic          tdo_o
);

  logic [FW-1:0] shift_q, shift_d;

  // Next-state: capture, shift or hold
  always_comb begin
    shift_d = shift_q;
    if (capture_i) begin
      shift_d = capture_data_i;
    end else if (shift_i) begin
      shift_d = {tdi_i, shift_q[FW-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign data_o = shift_q;
  assign tdo_o  = shift_q[0];

endmodule

// File: rtl/jtag_reg_bridge.sv
// ER1 user-chain to request/acknowledge register bus bridge (JTCK domain).
// A DR scan shifts in {we, addr, wdata}; the following Update-DR launches one
// bus transaction. Capture-DR returns {tmo, ovr, busy, rdata} (read-to-clear
// flags).
// Ports:
//   JTCK, JRSTN            clock, async active-low reset
//   JTDI, JSHIFT, JUPDATE  JTAGG user-chain signals (JUPDATE shared with ER2)
//   JCE1                   ER1 capture/shift enable
//   JTDO1                  serial out to JTAGG (combinational)
//   bus_req/we/addr/wdata  registered bus request outputs
//   bus_rdata, bus_ack     bus response (ack is a single-cycle pulse)
// Optional: define JTAG_REG_BRIDGE_TIMEOUT_EN to abort a request after
// TIMEOUT unacknowledged cycles (sets the timeout flag, rdata = all-ones).
module jtag_reg_bridge
  import jtag_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              JTCK,
  input  logic              JRSTN,
  input  logic              JTDI,
  input  logic              JSHIFT,
  input  logic              JUPDATE,
  input  logic              JCE1,
  output logic              JTDO1,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  localparam int unsigned FW = 1 + ADDR_W + DATA_W;

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ovr_q, ovr_d;
  logic              tmo_q, tmo_d;
  logic              ovr_set_c, tmo_set_c;
  logic              cap_c, shift_c, upd_c;
  logic [FW-1:0]     cap_data_c, frame_c;

`ifdef JTAG_REG_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout_c;
  assign unused_timeout_c = |TIMEOUT;
`endif

  assign cap_c   = JCE1 & ~JSHIFT;
  assign shift_c = JCE1 & JSHIFT;
  // JUPDATE is common to both user chains; only act if ER1 was last selected
  assign upd_c   = JUPDATE & sel_q;

  // Capture frame: read data plus status bits, upper bits zero
  always_comb begin
    cap_data_c = '0;
    cap_data_c[DATA_W-1:0]         = rdata_q;
    cap_data_c[DATA_W + STAT_BUSY] = (state_q != IDLE);
    cap_data_c[DATA_W + STAT_OVR]  = ovr_q;
    cap_data_c[DATA_W + STAT_TMO]  = tmo_q;
  end

  jtag_dr_shifter #(
    .FW (FW)
  ) u_shifter (
    .clk            (JTCK),
    .rst_n          (JRSTN),
    .capture_i      (cap_c),
    .shift_i        (shift_c),
    .tdi_i          (JTDI),
    .capture_data_i (cap_data_c),
    .data_o         (frame_c),
    .tdo_o          (JTDO1)
  );

  // Next-state: bus FSM, sticky flags and chain select
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ovr_d     = ovr_q;
    tmo_d     = tmo_q;
    ovr_set_c = 1'b0;
    tmo_set_c = 1'b0;
`ifdef JTAG_REG_BRIDGE_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (upd_c) begin
          we_d    = frame_c[FW-1];
          addr_d  = frame_c[DATA_W +: ADDR_W];
          wdata_d = frame_c[DATA_W-1:0];
          req_d   = 1'b1;
          state_d = REQ;
`ifdef JTAG_REG_BRIDGE_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ: begin
        // A new command while one is outstanding is dropped
        if (upd_c) begin
          ovr_set_c = 1'b1;
        end
        // Ack wins over a simultaneous timeout
        if (bus_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          if (!we_q) begin
            rdata_d = bus_rdata;
          end
        end
`ifdef JTAG_REG_BRIDGE_TIMEOUT_EN
        else if ((32'(cnt_q) + 32'd1) >= TIMEOUT) begin
          req_d     = 1'b0;
          state_d   = IDLE;
          rdata_d   = '1;
          tmo_set_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Read-to-clear on capture; a set in the same cycle wins
    if (cap_c) begin
      ovr_d = 1'b0;
      tmo_d = 1'b0;
    end
    if (ovr_set_c) ovr_d = 1'b1;
    if (tmo_set_c) tmo_d = 1'b1;

    if (JUPDATE) begin
      sel_d = 1'b0;
    end else if (JCE1) begin
      sel_d = 1'b1;
    end
  end

  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
`ifdef JTAG_REG_BRIDGE_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
`ifdef JTAG_REG_BRIDGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_jtag_reg_bridge.sv
// Bench for jtag_reg_bridge: drives JTAG scans and a bus responder, keeps a
// transaction-level reference model, and checks bus requests (monitor) and
// captured frames against queued expectations.
module tb_jtag_reg_bridge;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned FW  = 1 + AW + DW;
  localparam int unsigned TMO = 4;

  logic          JTCK = 1'b0;
  logic          JRSTN = 1'b1;
  logic          JTDI = 1'b0;
  logic          JSHIFT = 1'b0;
  logic          JUPDATE = 1'b0;
  logic          JCE1 = 1'b0;
  logic          JTDO1;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_ack = 1'b0;

  jtag_reg_bridge #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TMO)
  ) dut (
    .JTCK      (JTCK),
    .JRSTN     (JRSTN),
    .JTDI      (JTDI),
    .JSHIFT    (JSHIFT),
    .JUPDATE   (JUPDATE),
    .JCE1      (JCE1),
    .JTDO1     (JTDO1),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  always #5 JTCK = ~JTCK;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            cyc;
  } cmd_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int fall_cyc = -1;

  cmd_t          exp_cmd_q[$];
  logic [FW-1:0] exp_frame_q[$];

  // Reference model state
  logic          m_sel, m_busy, m_we, m_ovr, m_tmo;
  logic [DW-1:0] m_rdata;
  logic [FW-1:0] m_cmd;
  int            m_wait, m_reqcyc;
  logic          hang = 1'b0;
  int            fixed_wait = 0;
  logic          rd_fixed = 1'b0;
  logic [DW-1:0] rd_val = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sel = 1'b0; m_busy = 1'b0; m_we = 1'b0; m_ovr = 1'b0; m_tmo = 1'b0;
    m_rdata = '0; m_cmd = '0; m_wait = 0; m_reqcyc = 0;
    exp_cmd_q.delete();
    exp_frame_q.delete();
  endtask

  // Effect of one clock edge, computed from the pre-edge model state
  task automatic model_edge();
    logic          busy0, ovr_set, tmo_set;
    logic [FW-1:0] f;
    cmd_t          c;
    busy0 = m_busy; ovr_set = 1'b0; tmo_set = 1'b0;
    if (JCE1 && !JSHIFT) begin
      f = '0;
      f[DW-1:0] = m_rdata;
      f[DW]     = busy0;
      f[DW+1]   = m_ovr;
      f[DW+2]   = m_tmo;
      exp_frame_q.push_back(f);
    end
    if (busy0) begin
      if (bus_ack) begin
        m_busy = 1'b0;
        if (!m_we) m_rdata = bus_rdata;
      end
`ifdef JTAG_REG_BRIDGE_TIMEOUT_EN
      else if (m_reqcyc + 1 == int'(TMO)) begin
        m_busy = 1'b0; tmo_set = 1'b1; m_rdata = '1;
      end else begin
        m_reqcyc++;
      end
`endif
    end
    if (JUPDATE && m_sel) begin
      if (!busy0) begin
        c.we = m_cmd[FW-1]; c.addr = m_cmd[DW +: AW]; c.wdata = m_cmd[DW-1:0]; c.cyc = cyc;
        exp_cmd_q.push_back(c);
        m_busy = 1'b1; m_we = c.we; m_reqcyc = 0;
        if (fixed_wait != 0) m_wait = fixed_wait;
        else if ($urandom_range(0, 1) == 0) m_wait = int'($urandom_range(1, 5));
        else m_wait = int'($urandom_range(1, 60));
      end else begin
        ovr_set = 1'b1;
      end
    end
    if (JCE1 && !JSHIFT) begin m_ovr = 1'b0; m_tmo = 1'b0; end
    if (ovr_set) m_ovr = 1'b1;
    if (tmo_set) m_tmo = 1'b1;
    if (JUPDATE) m_sel = 1'b0;
    else if (JCE1) m_sel = 1'b1;
  endtask

  // One clock: responder drives ack, edge, model update, back at negedge
  task automatic tick();
    bus_ack = 1'b0;
    if (m_busy) begin
      if (!hang) begin
        if (m_wait <= 1) begin
          bus_ack = 1'b1;
          bus_rdata = rd_fixed ? rd_val : DW'($urandom);
        end else begin
          m_wait--;
        end
      end
    end else if ($urandom_range(0, 7) == 0) begin
      bus_ack = 1'b1;
      bus_rdata = DW'($urandom);
    end
    @(posedge JTCK);
    cyc++;
    if (JRSTN) model_edge();
    @(negedge JTCK);
  endtask

  task automatic idle(input int n);
    JCE1 = 1'b0; JSHIFT = 1'b0; JUPDATE = 1'b0;
    repeat (n) tick();
  endtask

  // Full ER1 scan: capture, FW shifts, exit, optional update, one idle cycle
  task automatic scan(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input logic upd);
    logic [FW-1:0] cmd, obs, expf;
    cmd = {we, addr, wd};
    obs = '0;
    JCE1 = 1'b1; JSHIFT = 1'b0; JUPDATE = 1'b0;
    tick();
    for (int k = 0; k < int'(FW); k++) begin
      JSHIFT = 1'b1; JTDI = cmd[k];
      obs[k] = JTDO1;
      tick();
    end
    m_cmd = cmd;
    JCE1 = 1'b0; JSHIFT = 1'b0; JTDI = 1'b0;
    tick();
    if (upd) begin
      JUPDATE = 1'b1;
      tick();
      JUPDATE = 1'b0;
    end
    tick();
    if (exp_frame_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL capture_frame actual=%0h required=<none queued>", obs);
    end else begin
      expf = exp_frame_q.pop_front();
      chk("capture_frame", 64'(obs), 64'(expf));
    end
  endtask

  task automatic wait_idle();
    idle(0);
    for (int i = 0; i < 3000 && m_busy; i++) tick();
    if (m_busy) begin
      checks++; errors++;
      $display("FAIL wait_idle actual=busy required=idle");
    end
    tick();
    chk("idle_req", 64'(bus_req), 64'd0);
  endtask

  // Bus monitor: pops the expected command on each request rising edge
  logic ack_edge = 1'b0;
  logic req_prev = 1'b0;
  cmd_t cur;
  always @(posedge JTCK) ack_edge <= bus_ack && bus_req;
  always @(negedge JTCK) begin
    if (bus_req && !req_prev) begin
      rise_cyc = cyc;
      if (exp_cmd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_req actual=req addr=%0h required=no req", bus_addr);
      end else begin
        cur = exp_cmd_q.pop_front();
        chk("req_we", 64'(bus_we), 64'(cur.we));
        chk("req_addr", 64'(bus_addr), 64'(cur.addr));
        chk("req_wdata", 64'(bus_wdata), 64'(cur.wdata));
        chk("req_latency", 64'(cyc), 64'(cur.cyc));
      end
    end else if (bus_req && req_prev) begin
      chk("hold_addr", 64'(bus_addr), 64'(cur.addr));
      chk("hold_we_wdata", 64'({bus_we, bus_wdata}), 64'({cur.we, cur.wdata}));
    end
    if (!bus_req && req_prev) fall_cyc = cyc;
    if (ack_edge) chk("req_drop_after_ack", 64'(bus_req), 64'd0);
    req_prev = bus_req;
  end

  initial begin
    model_reset();
    #1 JRSTN = 1'b0;
    @(negedge JTCK);
    repeat (2) tick();
    chk("rst_req", 64'(bus_req), 64'd0);
    chk("rst_we", 64'(bus_we), 64'd0);
    chk("rst_addr", 64'(bus_addr), 64'd0);
    chk("rst_wdata", 64'(bus_wdata), 64'd0);
    chk("rst_tdo", 64'(JTDO1), 64'd0);
    JRSTN = 1'b1;
    tick();

    // Directed write, ack in the third request cycle
    fixed_wait = 3;
    scan(1'b1, 8'h10, 32'hDEADBEEF, 1'b1);
    wait_idle();

    // Directed read, then capture the returned data
    fixed_wait = 2; rd_fixed = 1'b1; rd_val = 32'h12345678;
    scan(1'b0, 8'h04, 32'h0, 1'b1);
    wait_idle();
    rd_fixed = 1'b0; fixed_wait = 0;
    scan(1'b0, 8'h00, 32'h0, 1'b0);

    // Overrun: second command while the first is outstanding
    hang = 1'b1;
    scan(1'b1, 8'h20, 32'h11112222, 1'b1);
    scan(1'b1, 8'h30, 32'h33334444, 1'b1);
    scan(1'b0, 8'h00, 32'h0, 1'b0);
    scan(1'b0, 8'h00, 32'h0, 1'b0);
    hang = 1'b0;
    wait_idle();

    // ER2 isolation: a completed ER1 scan, then ER2-only activity
    scan(1'b0, 8'hA5, 32'h00000001, 1'b1);
    wait_idle();
    JCE1 = 1'b0; JSHIFT = 1'b1;
    for (int i = 0; i < 40; i++) begin
      JTDI = 1'($urandom);
      tick();
    end
    JSHIFT = 1'b0; JUPDATE = 1'b1;
    tick();
    JUPDATE = 1'b0;
    idle(3);
    chk("er2_tdo", 64'(JTDO1), 64'(m_cmd[0]));
    chk("er2_no_req", 64'(bus_req), 64'd0);
    scan(1'b0, 8'h00, 32'h0, 1'b0);

    // Request with no ack
    hang = 1'b1;
    scan(1'b0, 8'h08, 32'h0, 1'b1);
`ifdef JTAG_REG_BRIDGE_TIMEOUT_EN
    fall_cyc = -1;
    for (int i = 0; i < 50 && bus_req; i++) tick();
    chk("tmo_req_cycles", 64'(fall_cyc - rise_cyc), 64'(TMO));
    hang = 1'b0;
    scan(1'b0, 8'h00, 32'h0, 1'b0);
`else
    repeat (1000) tick();
    chk("no_tmo_req_held", 64'(bus_req), 64'd1);
    hang = 1'b0;
    wait_idle();
    scan(1'b0, 8'h00, 32'h0, 1'b0);
`endif
    wait_idle();

    // Reset in the middle of a transaction
    hang = 1'b1;
    scan(1'b1, 8'h55, 32'hCAFEF00D, 1'b1);
    tick();
    #2 JRSTN = 1'b0;
    #1 chk("rst_req_async", 64'(bus_req), 64'd0);
    model_reset();
    @(negedge JTCK);
    repeat (2) tick();
    JRSTN = 1'b1;
    hang = 1'b0;
    tick();
    scan(1'b0, 8'h00, 32'h0, 1'b0);

    // Randomized scans, gaps and ack latencies
    for (int it = 0; it < 40; it++) begin
      scan(1'($urandom), AW'($urandom), DW'($urandom), $urandom_range(0, 4) != 0);
      idle(int'($urandom_range(0, 6)));
    end
    wait_idle();
    scan(1'b0, 8'h00, 32'h0, 1'b0);
    wait_idle();
    chk("cmd_q_drained", 64'(exp_cmd_q.size()), 64'd0);
    chk("frame_q_drained", 64'(exp_frame_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
